// File: rtl/regfile_mp_if.sv
// Bus interface for regfile_mp: read ports, dual write ports, clear control.
// Scoreboard signals exist only when REGFILE_SCOREBOARD_EN is defined.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic                       clear_req;
   logic                       busy;
   logic [NUM_RD*ADDR_W-1:0]   rd_addr;
   logic [NUM_RD*DATA_W-1:0]   rd_data;
   logic [1:0]                 wr_ce;
   logic [2*ADDR_W-1:0]        wr_addr;
   logic [2*DATA_W-1:0]        wr_data;
`ifdef REGFILE_SCOREBOARD_EN
   logic                       issue_ce;
   logic [ADDR_W-1:0]          issue_addr;
   logic [DEPTH-1:0]           pending;

   modport master (
      output clear_req, rd_addr, wr_ce, wr_addr, wr_data, issue_ce, issue_addr,
      input  busy, rd_data, pending
   );
   modport slave (
      input  clear_req, rd_addr, wr_ce, wr_addr, wr_data, issue_ce, issue_addr,
      output busy, rd_data, pending
   );
`else
   modport master (
      output clear_req, rd_addr, wr_ce, wr_addr, wr_data,
      input  busy, rd_data
   );
   modport slave (
      input  clear_req, rd_addr, wr_ce, wr_addr, wr_data,
      output busy, rd_data
   );
`endif
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD read ports, two write ports (port 1 wins), r0 = 0,
// sequential clear engine. Optional pending-producer scoreboard: REGFILE_SCOREBOARD_EN.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic         clk,
   input  logic         rst,
   regfile_mp_if.slave  bus
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

   state_t              state;
   logic [ADDR_W-1:0]   clr_idx;
   logic                busy_q;
   logic                clr_done;
   logic [DATA_W-1:0]   regs [DEPTH];
   logic [ADDR_W-1:0]   wa [2];
   logic [DATA_W-1:0]   wd [2];
   logic [1:0]          we;

   assign clr_done = (state == CLEAR) && (clr_idx == LAST_IDX);
   assign bus.busy = busy_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= CLEAR;
         clr_idx <= FIRST_IDX;
         busy_q  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.clear_req) begin
                  state  <= CLEAR;
                  busy_q <= 1'b1;
               end
            end
            CLEAR: begin
               if (clr_done) begin
                  state   <= IDLE;
                  busy_q  <= 1'b0;
                  clr_idx <= FIRST_IDX;
               end else begin
                  clr_idx <= clr_idx + 1'b1;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

   // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         wa[p] = bus.wr_addr[p*ADDR_W +: ADDR_W];
         wd[p] = bus.wr_data[p*DATA_W +: DATA_W];
         we[p] = (state == IDLE) && bus.wr_ce[p] && (wa[p] != '0);
      end
   end

   // NOTE: the array has no reset; the clear engine zeroes it after every reset instead.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         regs[clr_idx] <= '0;
      end else begin
         // NOTE: non-blocking and port 1 scheduled last, so port 1 wins an address collision.
         for (int p = 0; p < 2; p++) begin
            if (we[p]) regs[wa[p]] <= wd[p];
         end
      end
   end

   always_comb begin
      bus.rd_data = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         logic [ADDR_W-1:0] ra;
         logic [DATA_W-1:0] val;
         ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
         if (state == CLEAR || ra == '0)
            val = '0;
         else if (bus.wr_ce[1] && wa[1] == ra)
            val = wd[1];
         else if (bus.wr_ce[0] && wa[0] == ra)
            val = wd[0];
         else
            val = regs[ra];
         bus.rd_data[i*DATA_W +: DATA_W] = val;
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [DEPTH-1:0] pending_q;

   // Issue is applied after the write-clears so a same-edge issue leaves the bit set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q <= '0;
      end else if (clr_done) begin
         pending_q <= '0;
      end else if (state == IDLE) begin
         for (int p = 0; p < 2; p++) begin
            if (we[p]) pending_q[wa[p]] <= 1'b0;
         end
         if (bus.issue_ce && bus.issue_addr != '0) pending_q[bus.issue_addr] <= 1'b1;
      end
   end

   assign bus.pending = pending_q;
`endif

endmodule
